// File: rtl/ledg_pwm_pkg.sv
// Shared constants for the LEDG PWM/blink driver: register map and reset values.
package ledg_pwm_pkg;

    localparam logic [1:0] ADDR_DUTY      = 2'd0;
    localparam logic [1:0] ADDR_BLINK_EN  = 2'd1;
    localparam logic [1:0] ADDR_BLINK_HLF = 2'd2;
    localparam logic [1:0] ADDR_STATUS    = 2'd3;

    localparam logic [31:0] DUTY_RST      = 32'hFFFF_FFFF;
    localparam logic [15:0] BLINK_HLF_RST = 16'h00FF;

    // Last blink_cnt value of a half-period; a programmed 0 behaves as 1.
    function automatic logic [15:0] blink_last(input logic [15:0] hlf);
        return (hlf == 16'd0) ? 16'd0 : hlf - 16'd1;
    endfunction

endpackage

// File: rtl/ledg_pwm_timebase.sv
// Prescaler, PWM counter and registered frame pulse for the LEDG driver.
module ledg_pwm_timebase #(
    parameter int PWM_BITS = 8,
    parameter int PRESCALE = 50
) (
    input  logic                clk,
    input  logic                reset,
    output logic [PWM_BITS-1:0] pwm_cnt,
    output logic                pwm_frame
);
    import ledg_pwm_pkg::*;

    localparam int PW = (PRESCALE > 1) ? $clog2(PRESCALE) : 1;
    localparam logic [PW-1:0] PRESC_LAST = PW'(PRESCALE - 1);

    logic [PW-1:0] presc;
    logic          tick;
    logic          wrap;

    assign tick = (presc == PRESC_LAST);
    assign wrap = tick && (pwm_cnt == '1);

    always_ff @(posedge clk) begin
        if (reset) begin
            presc     <= '0;
            pwm_cnt   <= '0;
            pwm_frame <= 1'b0;
        end else begin
            presc     <= tick ? '0 : presc + 1'b1;
            if (tick)
                pwm_cnt <= pwm_cnt + 1'b1;
            pwm_frame <= wrap;
        end
    end

endmodule

// File: rtl/de2_115_ledg_pwm_driver.sv
// LEDG pin driver: global PWM dimming, per-LED blink gating, Avalon-MM config port.
module de2_115_ledg_pwm_driver #(
    parameter int NUM_LEDS = 9,
    parameter int PWM_BITS = 8,
    parameter int PRESCALE = 50
) (
    input  logic                clk,
    input  logic                reset,
    input  logic [1:0]          address,
    input  logic                chipselect,
    input  logic                write_n,
    input  logic [31:0]         writedata,
    output logic [31:0]         readdata,
    input  logic [NUM_LEDS-1:0] led_in,
    output logic [NUM_LEDS-1:0] led_out,
    output logic                pwm_frame
);
    import ledg_pwm_pkg::*;

    logic [PWM_BITS-1:0] duty_reg;
    logic [PWM_BITS-1:0] duty_act;
    logic [NUM_LEDS-1:0] blink_en;
    logic [15:0]         blink_hlf;
    logic [15:0]         blink_cnt;
    logic                blink_phase;
    logic [PWM_BITS-1:0] pwm_cnt;
    logic                pwm_on;
    logic                wr_en;
    logic                hlf_wr;
    logic                unused_wd;

    assign unused_wd = ^writedata;

    ledg_pwm_timebase #(
        .PWM_BITS (PWM_BITS),
        .PRESCALE (PRESCALE)
    ) u_timebase (
        .clk       (clk),
        .reset     (reset),
        .pwm_cnt   (pwm_cnt),
        .pwm_frame (pwm_frame)
    );

    assign wr_en  = chipselect && !write_n;
    assign hlf_wr = wr_en && (address == ADDR_BLINK_HLF);

    always_ff @(posedge clk) begin
        if (reset) begin
            duty_reg  <= DUTY_RST[PWM_BITS-1:0];
            blink_en  <= '0;
            blink_hlf <= BLINK_HLF_RST;
        end else if (wr_en) begin
            case (address)
                ADDR_DUTY:      duty_reg  <= writedata[PWM_BITS-1:0];
                ADDR_BLINK_EN:  blink_en  <= writedata[NUM_LEDS-1:0];
                ADDR_BLINK_HLF: blink_hlf <= writedata[15:0];
                default: ;
            endcase
        end
    end

    // Reads reflect register state before any same-cycle write lands.
    always_comb begin
        readdata = '0;
        case (address)
            ADDR_DUTY:      readdata[PWM_BITS-1:0] = duty_reg;
            ADDR_BLINK_EN:  readdata[NUM_LEDS-1:0] = blink_en;
            ADDR_BLINK_HLF: readdata[15:0]         = blink_hlf;
            ADDR_STATUS: begin
                readdata[0]             = blink_phase;
                readdata[8 +: PWM_BITS] = pwm_cnt;
            end
            default: ;
        endcase
    end

    // Duty only changes at a frame boundary so a running period is never cut short.
    always_ff @(posedge clk) begin
        if (reset)
            duty_act <= '1;
        else if (pwm_frame)
            duty_act <= duty_reg;
    end

    assign pwm_on = (duty_act == '1) || (pwm_cnt < duty_act);

    // Reprogramming the half-period restarts the blink in the lit half.
    always_ff @(posedge clk) begin
        if (reset) begin
            blink_cnt   <= '0;
            blink_phase <= 1'b0;
        end else if (hlf_wr) begin
            blink_cnt   <= '0;
            blink_phase <= 1'b0;
        end else if (pwm_frame) begin
            if (blink_cnt == blink_last(blink_hlf)) begin
                blink_cnt   <= '0;
                blink_phase <= !blink_phase;
            end else begin
                blink_cnt <= blink_cnt + 16'd1;
            end
        end
    end

    always_ff @(posedge clk) begin
        if (reset)
            led_out <= '0;
        else
            led_out <= led_in & {NUM_LEDS{pwm_on}} & ~(blink_en & {NUM_LEDS{blink_phase}});
    end

endmodule

// File: tb/tb_de2_115_ledg_pwm_driver.sv
// Directed bench for the LEDG PWM driver with a 2-cycle prescale and 4-bit PWM (32-cycle frame).
module tb_de2_115_ledg_pwm_driver;
    localparam int NUM_LEDS = 9;
    localparam int PWM_BITS = 4;
    localparam int PRESCALE = 2;

    logic                clk = 1'b0;
    logic                reset;
    logic [1:0]          address;
    logic                chipselect;
    logic                write_n;
    logic [31:0]         writedata;
    logic [31:0]         readdata;
    logic [NUM_LEDS-1:0] led_in;
    logic [NUM_LEDS-1:0] led_out;
    logic                pwm_frame;

    int ncmp  = 0;
    int nfail = 0;

    always #5 clk = ~clk;

    de2_115_ledg_pwm_driver #(
        .NUM_LEDS (NUM_LEDS),
        .PWM_BITS (PWM_BITS),
        .PRESCALE (PRESCALE)
    ) dut (
        .clk        (clk),
        .reset      (reset),
        .address    (address),
        .chipselect (chipselect),
        .write_n    (write_n),
        .writedata  (writedata),
        .readdata   (readdata),
        .led_in     (led_in),
        .led_out    (led_out),
        .pwm_frame  (pwm_frame)
    );

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        ncmp++;
        assert (obs === exp) else begin
            nfail++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic wr(input logic [1:0] a, input logic [31:0] d);
        address    = a;
        writedata  = d;
        chipselect = 1'b1;
        write_n    = 1'b0;
        step();
        chipselect = 1'b0;
        write_n    = 1'b1;
    endtask

    task automatic rd(input string tag, input logic [1:0] a, input logic [31:0] exp);
        address = a;
        #1;
        chk(tag, readdata, exp);
    endtask

    task automatic wait_frame(output bit ok);
        ok = 1'b0;
        for (int i = 0; i < 80; i++) begin
            step();
            if (pwm_frame === 1'b1) begin
                ok = 1'b1;
                break;
            end
        end
    endtask

    // Steps until led_out[8] leaves the given level.
    task automatic wait_led8(input logic from, output bit ok);
        ok = 1'b0;
        for (int i = 0; i < 200; i++) begin
            step();
            if (led_out[8] !== from) begin
                ok = 1'b1;
                break;
            end
        end
    endtask

    // Called on the first sample of a new blink level: it must hold for half cycles, then flip.
    task automatic blink_period(input string tag, input int half);
        logic v;
        int   stable;
        int   low_bad;
        v       = led_out[8];
        stable  = 0;
        low_bad = 0;
        for (int k = 1; k < half; k++) begin
            step();
            if (led_out[8] === v) stable++;
            if (led_out[7:0] !== 8'hFF) low_bad++;
        end
        step();
        chk({tag, "_hold"}, stable, half - 1);
        chk({tag, "_flip"}, {31'd0, led_out[8]}, {31'd0, ~v});
        chk({tag, "_low8"}, low_bad, 0);
    endtask

    task automatic count_window(output int ones, output int upper);
        ones  = 0;
        upper = 0;
        for (int k = 0; k < 32; k++) begin
            step();
            if (led_out[0] === 1'b1) ones++;
            if (led_out[8:1] !== 8'h00) upper++;
        end
    endtask

    initial begin
        bit ok;
        int ones;
        int upper;

        reset      = 1'b1;
        address    = 2'd0;
        chipselect = 1'b0;
        write_n    = 1'b1;
        writedata  = 32'd0;
        led_in     = 9'h1FF;

        // Reset state
        step();
        step();
        chk("rst_led_out", {23'd0, led_out}, 32'd0);
        chk("rst_pwm_frame", {31'd0, pwm_frame}, 32'd0);
        rd("rst_duty", 2'd0, 32'h0000_000F);
        rd("rst_blink_en", 2'd1, 32'h0000_0000);
        rd("rst_blink_hlf", 2'd2, 32'h0000_00FF);
        rd("rst_status", 2'd3, 32'h0000_0000);
        reset = 1'b0;

        // 1: full duty passes the pattern through
        step();
        step();
        chk("t1_led_out", {23'd0, led_out}, 32'h0000_01FF);
        rd("t1_duty", 2'd0, 32'h0000_000F);

        // 2: duty 4 -> 8 of 32 cycles lit
        wr(2'd0, 32'd4);
        led_in = 9'h001;
        wait_frame(ok);
        chk("t2_frame_a", {31'd0, ok}, 32'd1);
        wait_frame(ok);
        chk("t2_frame_b", {31'd0, ok}, 32'd1);
        count_window(ones, upper);
        chk("t2_on_cycles", ones, 8);
        chk("t2_upper_dark", upper, 0);

        // 3: duty 0 -> dark; duty 15 -> continuously lit
        wr(2'd0, 32'd0);
        wait_frame(ok);
        wait_frame(ok);
        chk("t3_frame0", {31'd0, ok}, 32'd1);
        count_window(ones, upper);
        chk("t3_duty0_on", ones, 0);
        wr(2'd0, 32'd15);
        wait_frame(ok);
        wait_frame(ok);
        count_window(ones, upper);
        chk("t3_duty15_on", ones, 32);

        // 4: blink LED8 with 2-frame half-period
        led_in = 9'h1FF;
        wr(2'd1, 32'h100);
        wr(2'd2, 32'd2);
        wait_led8(1'b1, ok);
        chk("t4_blink_start", {31'd0, ok}, 32'd1);
        blink_period("t4", 64);

        // 5: reset in the dark half
        wait_led8(1'b1, ok);
        chk("t5_dark", {31'd0, ok}, 32'd1);
        for (int i = 0; i < 5; i++) step();
        reset = 1'b1;
        step();
        chk("t5_led_out", {23'd0, led_out}, 32'd0);
        chk("t5_pwm_frame", {31'd0, pwm_frame}, 32'd0);
        rd("t5_status", 2'd3, 32'h0000_0000);
        rd("t5_duty", 2'd0, 32'h0000_000F);
        rd("t5_blink_en", 2'd1, 32'h0000_0000);
        reset = 1'b0;

        // 6: half-period 0 behaves as 1; status writes ignored; read-during-write
        wr(2'd1, 32'h100);
        wr(2'd2, 32'd0);
        rd("t6_hlf0", 2'd2, 32'h0000_0000);
        wait_led8(1'b1, ok);
        chk("t6_blink_start", {31'd0, ok}, 32'd1);
        blink_period("t6", 32);
        wr(2'd3, 32'hFFFF_FFFF);
        rd("t6_a3_duty", 2'd0, 32'h0000_000F);
        rd("t6_a3_blink_en", 2'd1, 32'h0000_0100);
        rd("t6_a3_hlf", 2'd2, 32'h0000_0000);

        address    = 2'd0;
        writedata  = 32'd7;
        chipselect = 1'b1;
        write_n    = 1'b0;
        #1;
        chk("t6_rdw_pre", readdata, 32'h0000_000F);
        step();
        chipselect = 1'b0;
        write_n    = 1'b1;
        chk("t6_rdw_post", readdata, 32'h0000_0007);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", ncmp, nfail);
        $finish;
    end

endmodule
